// File: rtl/mac_tile_sequencer.sv
// mac_tile_sequencer: walks a tiled 64x64 product, issues A/B SRAM reads and hands finished columns to the PPU.
// Define MAC_SEQ_PERF_CNT_EN to add the saturating stall_cycles_o counter.
module mac_tile_sequencer #(
   parameter int ROW_GROUPS = 4,
   parameter int COLS       = 64,
   parameter int A_AW       = 7,
   parameter int B_AW       = 11
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_i,
   input  logic [1:0]                    mode_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic                          rd_en_o,
   output logic [A_AW-1:0]               addr_a_o,
   output logic [B_AW-1:0]               addr_b_o,
   output logic                          pipe_en_o,
   output logic                          is_int8_mode_o,
   output logic                          is_int4_mode_o,
   output logic                          acc_clear_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [$clog2(COLS)-1:0]       out_col_o,
   output logic [$clog2(ROW_GROUPS)-1:0] out_rg_o
`ifdef MAC_SEQ_PERF_CNT_EN
   ,
   output logic [15:0]                   stall_cycles_o
`endif
);
   localparam int RGW = $clog2(ROW_GROUPS);
   localparam int CW  = $clog2(COLS);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   typedef struct packed {
      logic           v;
      logic           first;
      logic           last;
      logic [CW-1:0]  col;
      logic [RGW-1:0] rg;
   } tag_t;
   state_t         state_q, state_d;
   logic           int8_q, int8_d;
   logic           ks_q, ks_d;
   logic [CW-1:0]  n_q, n_d;
   logic [RGW-1:0] rg_q, rg_d;
   logic           err_q, err_d;
   tag_t           s1_q, s2_q;
   logic           issue, legal, accept, last_ks, last_n, last_rg;
   logic [RGW:0]   a_idx;
   logic [CW:0]    b_idx;
   assign legal   = (mode_i == 2'b01) || (mode_i == 2'b10);
   assign accept  = (state_q == IDLE) && start_i && legal;
   // In int4 the only K-step is ks=0, so the last step is reached when ks equals the int8 flag.
   assign last_ks = ks_q == int8_q;
   assign last_n  = n_q == CW'(COLS - 1);
   assign last_rg = rg_q == RGW'(ROW_GROUPS - 1);
   assign out_valid_o    = s2_q.v && s2_q.last;
   assign pipe_en_o      = !(out_valid_o && !out_ready_i);
   assign acc_clear_o    = s1_q.v && s1_q.first && pipe_en_o;
   assign out_col_o      = s2_q.col;
   assign out_rg_o       = s2_q.rg;
   assign busy_o         = state_q != IDLE;
   assign done_o         = state_q == DONE;
   assign err_o          = err_q;
   assign rd_en_o        = issue;
   assign is_int8_mode_o = busy_o && int8_q;
   assign is_int4_mode_o = busy_o && !int8_q;
   assign a_idx    = int8_q ? {rg_q, ks_q} : {1'b0, rg_q};
   assign b_idx    = int8_q ? {n_q, ks_q} : {1'b0, n_q};
   assign addr_a_o = A_AW'(a_idx);
   assign addr_b_o = B_AW'(b_idx);
   always_comb begin
      state_d = state_q;
      int8_d  = int8_q;
      ks_d    = ks_q;
      n_d     = n_q;
      rg_d    = rg_q;
      err_d   = 1'b0;
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && legal) begin
               state_d = RUN;
               int8_d  = mode_i == 2'b01;
               ks_d    = 1'b0;
               n_d     = '0;
               rg_d    = '0;
            end
            err_d = start_i && !legal;
         end
         RUN: begin
            if (pipe_en_o) begin
               issue = 1'b1;
               ks_d  = last_ks ? 1'b0 : 1'b1;
               if (last_ks) begin
                  n_d = last_n ? '0 : n_q + 1'b1;
                  if (last_n) begin
                     rg_d = last_rg ? '0 : rg_q + 1'b1;
                     if (last_rg) state_d = DRAIN;
                  end
               end
            end
         end
         // Leave as soon as both tag stages will be empty after this edge.
         DRAIN:   state_d = (!s1_q.v && (!s2_q.v || pipe_en_o)) ? DONE : DRAIN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         int8_q  <= 1'b0;
         ks_q    <= 1'b0;
         n_q     <= '0;
         rg_q    <= '0;
         err_q   <= 1'b0;
         s1_q    <= '0;
         s2_q    <= '0;
      end else begin
         state_q <= state_d;
         int8_q  <= int8_d;
         ks_q    <= ks_d;
         n_q     <= n_d;
         rg_q    <= rg_d;
         err_q   <= err_d;
         if (pipe_en_o) begin
            s2_q <= s1_q;
            s1_q <= issue ? {1'b1, !ks_q, last_ks, n_q, rg_q} : '0;
         end
      end
   end
`ifdef MAC_SEQ_PERF_CNT_EN
   logic [15:0] stall_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else if (accept) stall_q <= '0;
      else if (busy_o && !pipe_en_o && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
   end
   assign stall_cycles_o = stall_q;
`endif
endmodule

// File: tb/tb_mac_tile_sequencer.sv
// tb_mac_tile_sequencer: directed checks of issue order, result handshake, stalls, reset and error paths.
// Define MAC_SEQ_PERF_CNT_EN to also check the stall counter.
module tb_mac_tile_sequencer;
   logic clk = 1'b0;
   logic rst_n, start_i, out_ready_i;
   logic [1:0] mode_i;
   logic busy_o, done_o, err_o, rd_en_o, pipe_en_o, is_int8_mode_o, is_int4_mode_o;
   logic acc_clear_o, out_valid_o;
   logic [6:0] addr_a_o;
   logic [10:0] addr_b_o;
   logic [5:0] out_col_o;
   logic [1:0] out_rg_o;
`ifdef MAC_SEQ_PERF_CNT_EN
   logic [15:0] stall_cycles_o;
`endif
   int checks = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mac_tile_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_en_o(rd_en_o),
      .addr_a_o(addr_a_o), .addr_b_o(addr_b_o), .pipe_en_o(pipe_en_o),
      .is_int8_mode_o(is_int8_mode_o), .is_int4_mode_o(is_int4_mode_o),
      .acc_clear_o(acc_clear_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_col_o(out_col_o), .out_rg_o(out_rg_o)
`ifdef MAC_SEQ_PERF_CNT_EN
      , .stall_cycles_o(stall_cycles_o)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, int'(busy_o), 0);
      chk({tag, "_done"}, int'(done_o), 0);
      chk({tag, "_err"}, int'(err_o), 0);
      chk({tag, "_rd_en"}, int'(rd_en_o), 0);
      chk({tag, "_addr_a"}, int'(addr_a_o), 0);
      chk({tag, "_addr_b"}, int'(addr_b_o), 0);
      chk({tag, "_pipe_en"}, int'(pipe_en_o), 1);
      chk({tag, "_int8"}, int'(is_int8_mode_o), 0);
      chk({tag, "_int4"}, int'(is_int4_mode_o), 0);
      chk({tag, "_acc_clear"}, int'(acc_clear_o), 0);
      chk({tag, "_out_valid"}, int'(out_valid_o), 0);
      chk({tag, "_out_col"}, int'(out_col_o), 0);
      chk({tag, "_out_rg"}, int'(out_rg_o), 0);
   endtask

   // Entered and left just after a rising edge; cycle 1 is the first cycle after start is sampled.
   task automatic run(input logic [1:0] m, input int stall_col, input int rst_col, input bit repulse);
      int k, iss, clears, beats, dcyc, stl, rg, n, ks;
      bit rdy, s1_first, new_first;
      k = (m == 2'b01) ? 2 : 1;
      {iss, clears, beats, dcyc, stl, rg, n, ks} = '0;
      s1_first = 1'b0;
      start_i = 1'b1;
      mode_i = m;
      @(negedge clk);
      @(posedge clk); #1;
      for (int c = 1; c <= 1200 && dcyc == 0; c++) begin
         start_i = repulse && (c == 100);
         rdy = !(stall_col >= 0 && out_valid_o && int'(out_col_o) == stall_col && out_rg_o == 2'd0 && stl < 5);
         out_ready_i = rdy;
         @(negedge clk);
         if (c == 1) begin
            chk("c1_busy", int'(busy_o), 1);
            chk("c1_int8", int'(is_int8_mode_o), int'(k == 2));
            chk("c1_int4", int'(is_int4_mode_o), int'(k == 1));
         end
         if (!rdy) begin
            stl++;
            chk("stall_pipe_en", int'(pipe_en_o), 0);
            chk("stall_rd_en", int'(rd_en_o), 0);
            chk("stall_col", int'(out_col_o), stall_col);
            chk("stall_addr_a", int'(addr_a_o), rg * k + ks);
            chk("stall_addr_b", int'(addr_b_o), n * k + ks);
         end
         if (acc_clear_o) begin
            clears++;
            chk("acc_clear_ks0", int'(s1_first), 1);
         end
         new_first = rd_en_o && ks == 0;
         if (pipe_en_o) s1_first = new_first;
         if (rd_en_o) begin
            iss++;
            chk("addr_a", int'(addr_a_o), rg * k + ks);
            chk("addr_b", int'(addr_b_o), n * k + ks);
            if (ks == k - 1) begin
               ks = 0;
               n = (n == 63) ? 0 : n + 1;
               if (n == 0) rg = (rg + 1) % 4;
            end else ks++;
         end
         if (out_valid_o && out_ready_i) begin
            chk("beat_col", int'(out_col_o), beats % 64);
            chk("beat_rg", int'(out_rg_o), beats / 64);
            if (stall_col < 0) chk("beat_cycle", c, k + 2 + beats * k);
            beats++;
            if (rst_col >= 0 && int'(out_col_o) == rst_col) begin
               rst_n = 1'b0;
               #1;
               chk_idle_outputs("midrst");
               @(posedge clk); #1;
               rst_n = 1'b1;
               @(posedge clk); #1;
               return;
            end
         end
         if (done_o) dcyc = c;
         @(posedge clk); #1;
      end
      out_ready_i = 1'b1;
      chk("done_cycle", dcyc, (k == 2 ? 515 : 259) + stl);
      chk("issue_count", iss, 256 * k);
      chk("beat_count", beats, 256);
      chk("acc_clear_count", clears, 256);
      @(negedge clk);
      chk("post_done_busy", int'(busy_o), 0);
      chk("post_done_done", int'(done_o), 0);
      chk("post_done_rd_en", int'(rd_en_o), 0);
      chk("post_done_int8", int'(is_int8_mode_o), 0);
      chk("post_done_int4", int'(is_int4_mode_o), 0);
`ifdef MAC_SEQ_PERF_CNT_EN
      chk("stall_cycles", int'(stall_cycles_o), stl);
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start_i = 1'b0;
      mode_i = 2'b00;
      out_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b1;
      mode_i = 2'b11;
      @(negedge clk);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      chk("illegal_err", int'(err_o), 1);
      chk("illegal_busy", int'(busy_o), 0);
      chk("illegal_rd_en", int'(rd_en_o), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("illegal_err_once", int'(err_o), 0);
         chk("illegal_busy_after", int'(busy_o), 0);
         chk("illegal_no_rd", int'(rd_en_o), 0);
      end
      @(posedge clk); #1;
      run(2'b01, -1, -1, 1'b0);
      run(2'b10, -1, -1, 1'b0);
      run(2'b01, 10, -1, 1'b0);
      run(2'b01, -1, 20, 1'b0);
      run(2'b01, -1, -1, 1'b0);
      run(2'b01, -1, -1, 1'b1);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
